// File: rtl/dmem_arbiter_if.sv
// Signal bundle around the data-memory arbiter: processor port, host port,
// memory strobes and the busy status. The arbiter uses the slave view, the
// requesters plus memory sit on the master view.
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          p_req;
  logic          p_wr;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic          p_ack;
  logic          p_rvalid;
  logic [DW-1:0] p_rdata;
  logic          h_req;
  logic          h_wr;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_lock;
  logic          h_ack;
  logic          h_rvalid;
  logic [DW-1:0] h_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  p_req, p_wr, p_addr, p_wdata,
    input  h_req, h_wr, h_addr, h_wdata, h_lock,
    input  mem_rdata,
    output p_ack, p_rvalid, p_rdata,
    output h_ack, h_rvalid, h_rdata,
    output mem_addr, mem_wr, mem_wdata, busy
  );

  modport master (
    output p_req, p_wr, p_addr, p_wdata,
    output h_req, h_wr, h_addr, h_wdata, h_lock,
    output mem_rdata,
    input  p_ack, p_rvalid, p_rdata,
    input  h_ack, h_rvalid, h_rdata,
    input  mem_addr, mem_wr, mem_wdata, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the
// processor (P) and a host/debug loader (H). One access is issued per ISSUE
// cycle from registered strobes; the host may lock the memory for atomic
// sequences. Read returns are tracked by a per-port RD_LAT-deep valid pipe.
module dmem_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic           clock,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic PORT_P = 1'b0;
  localparam logic PORT_H = 1'b1;

  state_t            state_r;
  logic              last_grant_r;
  logic              cur_port_r;
  logic              lock_r;
  logic              p_ack_r;
  logic              h_ack_r;
  logic              mem_wr_r;
  logic              busy_r;
  logic [AW-1:0]     mem_addr_r;
  logic [DW-1:0]     mem_wdata_r;
  logic [RD_LAT-1:0] p_pipe_r;
  logic [RD_LAT-1:0] h_pipe_r;
  logic [DW-1:0]     p_rdata_r;
  logic [DW-1:0]     h_rdata_r;

  logic              grant_p_s;
  logic              grant_h_s;
  logic              to_lock_s;
  logic              rd_issue_s;
  logic [RD_LAT-1:0] p_pipe_nxt_s;
  logic [RD_LAT-1:0] h_pipe_nxt_s;

  // Choose the requester latched at this edge; the port acked in ISSUE sits out the exit edge
  always_comb begin
    grant_p_s = 1'b0;
    grant_h_s = 1'b0;
    to_lock_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.p_req && bus.h_req) begin
          grant_p_s = (last_grant_r == PORT_H);
          grant_h_s = (last_grant_r == PORT_P);
        end else begin
          grant_p_s = bus.p_req;
          grant_h_s = bus.h_req;
        end
      end
      ST_ISSUE: begin
        if ((cur_port_r == PORT_H) && lock_r) begin
          to_lock_s = 1'b1;
        end else if (cur_port_r == PORT_H) begin
          grant_p_s = bus.p_req;
        end else begin
          grant_h_s = bus.h_req;
        end
      end
      ST_LOCKED: begin
        grant_h_s = bus.h_req;
      end
      default: begin
        grant_p_s = 1'b0;
        grant_h_s = 1'b0;
        to_lock_s = 1'b0;
      end
    endcase
  end

  // A read in ISSUE drops a tag for its port into the return pipe
  always_comb begin
    rd_issue_s   = (state_r == ST_ISSUE) && !mem_wr_r;
    p_pipe_nxt_s = (p_pipe_r << 1'b1) | RD_LAT'(rd_issue_s && (cur_port_r == PORT_P));
    h_pipe_nxt_s = (h_pipe_r << 1'b1) | RD_LAT'(rd_issue_s && (cur_port_r == PORT_H));
  end

  // Arbitration FSM with registered acks and memory strobes
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      last_grant_r <= PORT_H;
      cur_port_r   <= PORT_P;
      lock_r       <= 1'b0;
      p_ack_r      <= 1'b0;
      h_ack_r      <= 1'b0;
      mem_wr_r     <= 1'b0;
      busy_r       <= 1'b0;
      mem_addr_r   <= {AW{1'b0}};
      mem_wdata_r  <= {DW{1'b0}};
    end else begin
      p_ack_r <= grant_p_s;
      h_ack_r <= grant_h_s;
      if (grant_p_s || grant_h_s) begin
        state_r      <= ST_ISSUE;
        busy_r       <= 1'b1;
        cur_port_r   <= grant_h_s;
        last_grant_r <= grant_h_s;
        lock_r       <= grant_h_s && bus.h_lock;
        mem_wr_r     <= grant_h_s ? bus.h_wr    : bus.p_wr;
        mem_addr_r   <= grant_h_s ? bus.h_addr  : bus.p_addr;
        mem_wdata_r  <= grant_h_s ? bus.h_wdata : bus.p_wdata;
      end else begin
        mem_wr_r <= 1'b0;
        case (state_r)
          ST_ISSUE: begin
            if (to_lock_s) begin
              state_r <= ST_LOCKED;
              busy_r  <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end
          ST_LOCKED: begin
            // h_req is low here (otherwise H would have been granted)
            if (bus.h_lock) begin
              state_r <= ST_LOCKED;
              busy_r  <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Read-return pipes and read-data hold registers; reset drops in-flight reads
  always_ff @(posedge clock) begin
    if (reset) begin
      p_pipe_r  <= {RD_LAT{1'b0}};
      h_pipe_r  <= {RD_LAT{1'b0}};
      p_rdata_r <= {DW{1'b0}};
      h_rdata_r <= {DW{1'b0}};
    end else begin
      p_pipe_r <= p_pipe_nxt_s;
      h_pipe_r <= h_pipe_nxt_s;
      if (p_pipe_r[RD_LAT-1]) begin
        p_rdata_r <= bus.mem_rdata;
      end else begin
        p_rdata_r <= p_rdata_r;
      end
      if (h_pipe_r[RD_LAT-1]) begin
        h_rdata_r <= bus.mem_rdata;
      end else begin
        h_rdata_r <= h_rdata_r;
      end
    end
  end

  // Read data arrives from memory in the rvalid cycle itself, so it is passed
  // straight through then and held from the register afterwards.
  assign bus.p_ack     = p_ack_r;
  assign bus.h_ack     = h_ack_r;
  assign bus.p_rvalid  = p_pipe_r[RD_LAT-1];
  assign bus.h_rvalid  = h_pipe_r[RD_LAT-1];
  assign bus.p_rdata   = p_pipe_r[RD_LAT-1] ? bus.mem_rdata : p_rdata_r;
  assign bus.h_rdata   = h_pipe_r[RD_LAT-1] ? bus.mem_rdata : h_rdata_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wr    = mem_wr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.busy      = busy_r;

endmodule
